// File: rtl/idct_pkg.sv
// Shared definitions for the time-shared 8-point IDCT: state encoding, cosine constant table
// generator and the round-half-up arithmetic shift used on the butterfly outputs.
package idct_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] BFLY = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    function automatic real cos16(input int m);
        case (m)
            0:       return 1.0;
            1:       return 0.9807852804032304;
            2:       return 0.9238795325112867;
            3:       return 0.8314696123025452;
            4:       return 0.7071067811865476;
            5:       return 0.5555702330196022;
            6:       return 0.3826834323650898;
            7:       return 0.1950903220161283;
            default: return 0.0;
        endcase
    endfunction

    // K[k][n] = round(c(k)/2 * cos((2n+1)k*pi/16) * 2^frac), clamped to a const_w signed range.
    function automatic int idct_k(input int k, input int n, input int const_w, input int frac);
        int  m;
        int  r;
        int  lim;
        real c;
        real v;
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        c = (m > 8) ? -cos16(16 - m) : cos16(m);
        v = c * $itor(1 << frac) / 2.0;
        if (k == 0) v = v * 0.7071067811865476;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        lim = (1 << (const_w - 1)) - 1;
        if (r > lim) r = lim;
        else if (r < -lim - 1) r = -lim - 1;
        return r;
    endfunction

    function automatic longint round_shift(input longint v, input int frac);
        return (v + (longint'(1) <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/idct8_chen_ts_if.sv
// Coefficient-in / sample-out valid-ready bundle for idct8_chen_ts.
interface idct8_chen_ts_if #(
    parameter int IN_W = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [IN_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;

    modport master (
        output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        input  in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7
    );

    modport slave (
        input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        output in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7
    );
endinterface

// File: rtl/idct8_mac4.sv
// Combinational 4-term signed dot product, full-precision products sign-extended into S_W.
// Latency: 0 cycles. Backpressure: none (pure combinational).
module idct8_mac4 #(
    parameter int A_W = 32,
    parameter int B_W = 8,
    parameter int S_W = 43
) (
    input  logic signed [A_W-1:0] a [4],
    input  logic signed [B_W-1:0] b [4],
    output logic signed [S_W-1:0] sum
);
    logic signed [A_W+B_W-1:0] prod [4];

    always_comb begin
        sum = '0;
        for (int j = 0; j < 4; j++) begin
            prod[j] = (A_W+B_W)'(a[j]) * (A_W+B_W)'(b[j]);
            sum     = sum + S_W'(prod[j]);
        end
    end
endmodule

// File: rtl/idct8_chen_ts.sv
// Time-shared 8-point Chen IDCT; IDCT_SAT_EN selects output saturation instead of wrap.
// Latency: accept in cycle T -> out_valid in T+6; one vector per 7 cycles with out_ready high.
// Backpressure: results held stable in OUT until out_ready; in_ready only asserted in IDLE.
module idct8_chen_ts
    import idct_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CONST_W = 8,
    parameter int FRAC    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    idct8_chen_ts_if.slave io
);
    localparam int ACC_W = IN_W + CONST_W + 3;

`ifdef IDCT_SAT_EN
    localparam longint SAT_MAX = (longint'(1) <<< (IN_W - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (IN_W - 1));
`endif

    logic [1:0]                state;
    logic [1:0]                cnt;
    logic                      out_vld;
    logic signed [IN_W-1:0]    in_vec   [8];
    logic signed [IN_W-1:0]    x_dat    [8];
    logic signed [IN_W-1:0]    out_dat  [8];
    logic signed [IN_W-1:0]    bfly_dat [8];
    logic signed [ACC_W-1:0]   e_acc    [4];
    logic signed [ACC_W-1:0]   o_acc    [4];
    logic signed [CONST_W-1:0] k_tab    [8][4];
    logic signed [IN_W-1:0]    ev_x     [4];
    logic signed [IN_W-1:0]    od_x     [4];
    logic signed [CONST_W-1:0] ev_k     [4];
    logic signed [CONST_W-1:0] od_k     [4];
    logic signed [ACC_W-1:0]   ev_sum;
    logic signed [ACC_W-1:0]   od_sum;

    for (genvar k = 0; k < 8; k++) begin : g_k
        for (genvar n = 0; n < 4; n++) begin : g_n
            localparam int KV = idct_k(k, n, CONST_W, FRAC);
            assign k_tab[k][n] = CONST_W'(KV);
        end
    end

    always_comb begin
        in_vec[0] = io.in0; in_vec[1] = io.in1; in_vec[2] = io.in2; in_vec[3] = io.in3;
        in_vec[4] = io.in4; in_vec[5] = io.in5; in_vec[6] = io.in6; in_vec[7] = io.in7;
    end

    // Even coefficients feed one MAC, odd the other; cnt picks the column n of the table.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            ev_x[j] = x_dat[2*j];
            od_x[j] = x_dat[2*j+1];
            ev_k[j] = k_tab[2*j][cnt];
            od_k[j] = k_tab[2*j+1][cnt];
        end
    end

    idct8_mac4 #(.A_W(IN_W), .B_W(CONST_W), .S_W(ACC_W)) u_mac_even (
        .a(ev_x), .b(ev_k), .sum(ev_sum)
    );

    idct8_mac4 #(.A_W(IN_W), .B_W(CONST_W), .S_W(ACC_W)) u_mac_odd (
        .a(od_x), .b(od_k), .sum(od_sum)
    );

    function automatic logic signed [IN_W-1:0] reduce_out(input logic signed [ACC_W-1:0] y);
        longint r;
        r = round_shift(longint'(y), FRAC);
`ifdef IDCT_SAT_EN
        if (r > SAT_MAX) r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
`endif
        return IN_W'(r);
    endfunction

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            bfly_dat[n]     = reduce_out(e_acc[n] + o_acc[n]);
            bfly_dat[7 - n] = reduce_out(e_acc[n] - o_acc[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            out_vld <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                x_dat[i]   <= '0;
                out_dat[i] <= '0;
            end
            for (int j = 0; j < 4; j++) begin
                e_acc[j] <= '0;
                o_acc[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    x_dat <= in_vec;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    e_acc[cnt] <= ev_sum;
                    o_acc[cnt] <= od_sum;
                    cnt        <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= BFLY;
                end
                BFLY: begin
                    out_dat <= bfly_dat;
                    out_vld <= 1'b1;
                    state   <= OUT;
                end
                OUT: if (io.out_ready) begin
                    out_vld <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = out_vld;
    assign io.out0 = out_dat[0];
    assign io.out1 = out_dat[1];
    assign io.out2 = out_dat[2];
    assign io.out3 = out_dat[3];
    assign io.out4 = out_dat[4];
    assign io.out5 = out_dat[5];
    assign io.out6 = out_dat[6];
    assign io.out7 = out_dat[7];
endmodule

// File: tb/tb_idct8_chen_ts.sv
// Directed and random checks of idct8_chen_ts against an integer model with a hand-entered K table.
module tb_idct8_chen_ts;

    localparam int KT [8][4] = '{
        '{ 91,   91,   91,   91},
        '{126,  106,   71,   25},
        '{118,   49,  -49, -118},
        '{106,  -25, -126,  -71},
        '{ 91,  -91,  -91,   91},
        '{ 71, -126,   25,  106},
        '{ 49, -118,  118,  -49},
        '{ 25,  -71,  106, -126}
    };

    typedef struct { longint v [8]; } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    idct8_chen_ts_if #(.IN_W(32)) bus32 ();
    idct8_chen_ts_if #(.IN_W(8))  bus8 ();

    idct8_chen_ts #(.IN_W(32), .CONST_W(8), .FRAC(8)) dut (.clk(clk), .rst_n(rst_n), .io(bus32));
    idct8_chen_ts #(.IN_W(8),  .CONST_W(8), .FRAC(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(bus8));

    function automatic longint golden(input vec_t x, input int i, input int in_w);
        longint e, o, y, r, span;
        int n;
        n = (i < 4) ? i : 7 - i;
        e = 0;
        o = 0;
        for (int j = 0; j < 4; j++) begin
            e += x.v[2*j]   * longint'(KT[2*j][n]);
            o += x.v[2*j+1] * longint'(KT[2*j+1][n]);
        end
        y = (i < 4) ? e + o : e - o;
        r = (y + 128) >>> 8;
        span = longint'(1) <<< in_w;
`ifdef IDCT_SAT_EN
        if (r > span / 2 - 1) r = span / 2 - 1;
        else if (r < -span / 2) r = -span / 2;
`else
        r = r & (span - 1);
        if (r >= span / 2) r = r - span;
`endif
        return r;
    endfunction

    task automatic set32(input vec_t x);
        bus32.in0 = 32'(x.v[0]); bus32.in1 = 32'(x.v[1]);
        bus32.in2 = 32'(x.v[2]); bus32.in3 = 32'(x.v[3]);
        bus32.in4 = 32'(x.v[4]); bus32.in5 = 32'(x.v[5]);
        bus32.in6 = 32'(x.v[6]); bus32.in7 = 32'(x.v[7]);
    endtask

    task automatic set8(input vec_t x);
        bus8.in0 = 8'(x.v[0]); bus8.in1 = 8'(x.v[1]);
        bus8.in2 = 8'(x.v[2]); bus8.in3 = 8'(x.v[3]);
        bus8.in4 = 8'(x.v[4]); bus8.in5 = 8'(x.v[5]);
        bus8.in6 = 8'(x.v[6]); bus8.in7 = 8'(x.v[7]);
    endtask

    function automatic longint out32(input int i);
        case (i)
            0: return longint'(bus32.out0);
            1: return longint'(bus32.out1);
            2: return longint'(bus32.out2);
            3: return longint'(bus32.out3);
            4: return longint'(bus32.out4);
            5: return longint'(bus32.out5);
            6: return longint'(bus32.out6);
            default: return longint'(bus32.out7);
        endcase
    endfunction

    function automatic longint out8(input int i);
        case (i)
            0: return longint'(bus8.out0);
            1: return longint'(bus8.out1);
            2: return longint'(bus8.out2);
            3: return longint'(bus8.out3);
            4: return longint'(bus8.out4);
            5: return longint'(bus8.out5);
            6: return longint'(bus8.out6);
            default: return longint'(bus8.out7);
        endcase
    endfunction

    function automatic vec_t vec_const(input longint x0, input longint rest);
        vec_t x;
        x.v[0] = x0;
        for (int j = 1; j < 8; j++) x.v[j] = rest;
        return x;
    endfunction

    task automatic send32(input vec_t x);
        int guard;
        guard = 0;
        @(negedge clk);
        set32(x);
        bus32.in_valid = 1'b1;
        while (!bus32.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL send32_accept: in_ready stayed %0b for %0d cycles, required 1", bus32.in_ready, guard);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
    endtask

    task automatic wait_out32();
        int guard;
        guard = 0;
        while (!bus32.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL wait_out32: out_valid stayed %0b for %0d cycles, required 1", bus32.out_valid, guard);
        end
    endtask

    task automatic test_reset();
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0;
        set32(vec_const(0, 0));
        set8(vec_const(0, 0));
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %0b required 0", bus32.out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out32(i) !== 0) begin
                n_fail++;
                $display("FAIL reset_out%0d: got %0d required 0", i, out32(i));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus32.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b/%0b required 1/1", bus32.in_ready, bus8.in_ready);
        end
    endtask

    task automatic test_zero_latency();
        bus32.out_ready = 1'b1;
        @(negedge clk);
        set32(vec_const(0, 0));
        bus32.in_valid = 1'b1;
        n_tests++;
        if (bus32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_accept_ready: got %0b required 1", bus32.in_ready);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus32.in_valid = 1'b0;
            n_tests++;
            if (bus32.out_valid !== (k == 6) || bus32.in_ready !== (k == 7)) begin
                n_fail++;
                $display("FAIL zero_timing_T+%0d: out_valid=%0b in_ready=%0b required %0b/%0b",
                         k, bus32.out_valid, bus32.in_ready, (k == 6), (k == 7));
            end
            if (k == 6) begin
                for (int i = 0; i < 8; i++) begin
                    n_tests++;
                    if (out32(i) !== 0) begin
                        n_fail++;
                        $display("FAIL zero_out%0d: got %0d required 0", i, out32(i));
                    end
                end
            end
        end
    endtask

    task automatic test_dc();
        bus32.out_ready = 1'b1;
        send32(vec_const(64, 0));
        wait_out32();
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out32(i) !== 23) begin
                n_fail++;
                $display("FAIL dc_out%0d: got %0d required 23", i, out32(i));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int extra;
        bus32.out_ready = 1'b0;
        send32(vec_const(64, 0));
        wait_out32();
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: out_valid=%0b in_ready=%0b required 1/0", c, bus32.out_valid, bus32.in_ready);
            end
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (out32(i) !== 23) begin
                    n_fail++;
                    $display("FAIL bp_out%0d_c%0d: got %0d required 23", i, c, out32(i));
                end
            end
            set32(vec_const(1000, -500));
            bus32.in_valid = (c % 2 == 1);
            @(negedge clk);
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", bus32.out_valid, bus32.in_ready);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus32.out_valid) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL bp_ignored_pulses: got %0d extra output cycles required 0", extra);
        end
    endtask

    task automatic test_overflow();
        vec_t x;
        int   guard;
        longint exp0;
        x = vec_const(127, 127);
`ifdef IDCT_SAT_EN
        exp0 = 127;
`else
        exp0 = 80;
`endif
        @(negedge clk);
        set8(x);
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        guard = 0;
        while (!bus8.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL ovf_wait: out_valid stayed %0b required 1", bus8.out_valid);
        end
        n_tests++;
        if (out8(0) !== exp0) begin
            n_fail++;
            $display("FAIL ovf_out0_hand: got %0d required %0d", out8(0), exp0);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out8(i) !== golden(x, i, 8)) begin
                n_fail++;
                $display("FAIL ovf_out%0d: got %0d required %0d", i, out8(i), golden(x, i, 8));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        vec_t x;
        int   seen;
        bus32.out_ready = 1'b1;
        send32(vec_const(300, 40));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus32.out_valid) seen++;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 0 || bus32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_discard: out_valid cycles=%0d in_ready=%0b required 0/1", seen, bus32.in_ready);
        end
        x.v = '{-1200, 350, 77, -9, 4000, -31, 18, 5};
        send32(x);
        wait_out32();
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out32(i) !== golden(x, i, 32)) begin
                n_fail++;
                $display("FAIL rstmid_out%0d: got %0d required %0d", i, out32(i), golden(x, i, 32));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        vec_t q [$];
        vec_t cur;
        vec_t ex;
        int   sent;
        int   got;
        bit   accepted;
        sent = 0;
        got  = 0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) cur.v[j] = longint'(int'($urandom));
        set32(cur);
        bus32.in_valid = 1'b1;
        for (int cyc = 0; cyc < 600 && got < N; cyc++) begin
            bus32.out_ready = ($urandom_range(0, 3) != 0);
            if (bus32.out_valid && bus32.out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious: output %0d with no vector in flight", got);
                end else begin
                    ex = q.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        if (i > 0) n_tests++;
                        if (out32(i) !== golden(ex, i, 32)) begin
                            n_fail++;
                            $display("FAIL b2b_vec%0d_out%0d: got %0d required %0d", got, i, out32(i), golden(ex, i, 32));
                        end
                    end
                end
                got++;
            end
            accepted = bus32.in_valid && bus32.in_ready;
            if (accepted) q.push_back(cur);
            @(negedge clk);
            if (accepted) begin
                sent++;
                if (sent < N) begin
                    for (int j = 0; j < 8; j++)
                        cur.v[j] = (sent % 2 == 0) ? longint'(int'($urandom))
                                                   : longint'($urandom_range(0, 2000)) - 1000;
                    set32(cur);
                end else begin
                    bus32.in_valid = 1'b0;
                end
            end
        end
        bus32.in_valid = 1'b0;
        n_tests++;
        if (got !== N) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs required %0d", got, N);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_latency();
        test_dc();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idct8_chen_ts.md
# idct8_chen_ts

Time-shared 8-point inverse DCT (Chen even/odd decomposition) that reconstructs eight spatial samples from eight DCT coefficients. It is the decode-side counterpart of the forward `dct8_chen_ts` in the image compression datapath. It sits after dequantisation and is driven row-wise or column-wise by the 2-D transpose controller. It uses the same valid/ready handshake, port naming and fixed-point constant scheme as the forward transform, so both can share one sweep/wrapper flow.

## Interface
- `IN_W`, 32: signed width of input coefficients and output samples.
- `CONST_W`, 8: signed width of each cosine constant.
- `FRAC`, 8: fractional bits of the constants; also the output right-shift.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  coefficient vector valid.
- `in_ready`  output  1  block can accept a vector; equals (state == IDLE).
- `in0`..`in7`  input  IN_W each  signed coefficients X[0]..X[7].
- `out_valid`  output  1  sample vector valid.
- `out_ready`  input  1  downstream accepts the vector.
- `out0`..`out7`  output  IN_W each  signed samples x[0]..x[7].

## Operation
- Constants: K[k][n] = round(c(k)/2 · cos((2n+1)kπ/16) · 2^FRAC), with c(0)=1/√2 and c(k≠0)=1. Each constant is CONST_W signed.
- Even part: e[n] = Σ_{j=0..3} X[2j]·K[2j][n]. Odd part: o[n] = Σ_{j=0..3} X[2j+1]·K[2j+1][n], for n=0..3.
- Butterfly: y[n] = e[n]+o[n] and y[7-n] = e[n]−o[n].
- Output: x[i] = (y[i] + 2^(FRAC-1)) >>> FRAC (arithmetic shift), then reduced to IN_W.
- Widths: product IN_W+CONST_W; accumulators and y carry IN_W+CONST_W+3 bits, so no internal overflow.
- States:
  - IDLE: in_ready=1. On in_valid, latch in0..in7, cnt←0, go to CALC.
  - CALC: each cycle computes e[cnt] and o[cnt] (8 multipliers, two 4-term sums) into accumulator slot cnt. cnt increments; after cnt==3, go to BFLY.
  - BFLY: butterfly plus rounding; register out0..out7; out_valid←1; go to OUT.
  - OUT: hold outputs stable. On out_ready, out_valid←0 and go to IDLE.
- in_valid is ignored outside IDLE. The input latch is never overwritten mid-computation.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0, out_valid=0, out0..out7=0, accumulators=0. in_ready reads 1 once rst_n is high.
- Latency: if the accept handshake happens in cycle T, out_valid is high in cycle T+6.
- Throughput with out_ready held at 1: one vector per 7 cycles. in_ready is low from T+1 until the cycle after the output handshake.
- Backpressure: OUT persists indefinitely. out0..out7 and out_valid stay stable while out_ready=0.
- Reset asserted mid-CALC or mid-OUT: the in-flight vector is discarded, with no partial output. After release the block is in IDLE.
- An output handshake and a new in_valid cannot coincide, because in_ready=0 in OUT. The new vector is accepted in the following IDLE cycle.

## Configuration
- `IDCT_SAT_EN` defined: x[i] saturates to [−2^(IN_W-1), 2^(IN_W-1)−1].
- `IDCT_SAT_EN` undefined: x[i] is the low IN_W bits of the shifted value (two's-complement wrap).
- Latency and handshake are identical in both builds.

## Structure
- `idct_pkg`:
  - state enum (IDLE, CALC, BFLY, OUT);
  - constant function `idct_k(k, n, CONST_W, FRAC)` returning K[k][n];
  - a shared `round_shift` function.
- Sub-module `idct8_mac4`: combinational 4-term signed dot product with parameterised widths. It is instantiated twice, once for the even part and once for the odd part.
- Top level holds the FSM, cnt, input latch, accumulator bank, butterfly and output registers.

## Test plan
- Reset, then all-zero coefficients, out_ready=1 → out_valid at T+6, all outputs 0, in_ready back to 1 at T+7.
- DC input, IN_W=32, CONST_W=8, FRAC=8, X[0]=64, others 0 → all eight outputs = 23 (K[0][n]=91).
- Backpressure: DC vector with out_ready=0 for 10 cycles → outputs stable at 23, out_valid=1 and in_ready=0 throughout, in_valid pulses ignored. Raise out_ready → single handshake, then IDLE.
- Overflow, IN_W=8, all X[k]=127 → with `IDCT_SAT_EN`, out0=127; without it, out0 = low 8 bits of the shifted sum. Compare against the golden model.
- Reset mid-CALC (rst_n low 2 cycles at T+3) → out_valid never rises for that vector; the next vector's result matches the golden model.
- Random back-to-back vectors with random out_ready → bit-exact against the integer golden model using the same K table and rounding.
